// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and constants for the data-memory path.
package mem_if_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} mem_state_e;
    localparam logic MEM_OP_READ         = 1'b0;
    localparam logic MEM_OP_WRITE        = 1'b1;
    localparam int   DEFAULT_WAIT_CYCLES = 2;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 4-bit down-counter that stops at zero.
// Ports: clk, rst (async, active-high), load_i/load_val_i load a new count,
// en_i decrements, zero_o flags a count of zero.
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [3:0] load_val_i,
    output logic       zero_o
);
    logic [3:0] cnt_q, cnt_d;
    assign zero_o = cnt_q == 4'd0;
    assign cnt_d  = load_i ? load_val_i : (en_i && !zero_o) ? cnt_q - 4'd1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/sram_mem_port.sv
// sram_mem_port: single-word load/store responder driving an async SRAM.
// Ports: req_* request handshake and payload in; rsp_valid/rsp_rdata one-cycle
// completion strobe and read data out; sram_* registered SRAM pins, with
// sram_dq_out/sram_dq_oe forming the tristate data driver.
module sram_mem_port
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_mem_port: WAIT_CYCLES must be within 1..15");
    end
    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);
    mem_state_e        state_q;
    logic              we_q, ready_q, rsp_valid_q, dq_oe_q, ce_n_q, oe_n_q, we_n_q;
    logic [DATA_W-1:0] rdata_q, dq_out_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wait_zero;
    mem_wait_counter u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == SETUP),
        .en_i       (state_q == ACCESS),
        .load_val_i (LOAD_VAL),
        .zero_o     (wait_zero)
    );
    // Pins are registered from the state being entered, so each cycle shows
    // the pin levels of the state it is in with no path from req_* to pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= MEM_OP_READ;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        ce_n_q  <= 1'b0;
                        if (req_we == MEM_OP_WRITE) begin
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= req_wdata;
                        end else begin
                            oe_n_q <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    we_n_q  <= we_q != MEM_OP_WRITE;
                end
                ACCESS: begin
                    if (wait_zero) begin
                        state_q <= HOLD;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        if (we_q == MEM_OP_READ) rdata_q <= sram_dq_in;
                    end
                end
                HOLD: begin
                    state_q     <= IDLE;
                    ce_n_q      <= 1'b1;
                    dq_oe_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end
    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_mem_port.sv
// tb_sram_mem_port: directed bench for sram_mem_port at WAIT_CYCLES 2 and 1.
module tb_sram_mem_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] rsp_rdata, sram_addr, sram_dq_out, sram_dq_in;
    logic        r1_valid = 1'b0, r1_we = 1'b0;
    logic [15:0] r1_addr = '0, r1_wdata = '0;
    logic        w1_ready, w1_rsp_valid, w1_dq_oe, w1_ce_n, w1_oe_n, w1_we_n;
    logic [15:0] w1_rdata, w1_addr, w1_dq_out, w1_dq_in;
    logic [15:0] mem  [0:255];
    logic [15:0] mem1 [0:255];
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    sram_mem_port #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_mem_port #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(w1_ready), .req_we(r1_we),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .rsp_valid(w1_rsp_valid), .rsp_rdata(w1_rdata),
        .sram_addr(w1_addr), .sram_dq_out(w1_dq_out), .sram_dq_oe(w1_dq_oe),
        .sram_dq_in(w1_dq_in), .sram_ce_n(w1_ce_n), .sram_oe_n(w1_oe_n), .sram_we_n(w1_we_n)
    );

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
        if (!w1_ce_n && !w1_we_n) mem1[w1_addr[7:0]] <= w1_dq_out;
    end
    assign sram_dq_in = !sram_oe_n ? mem[sram_addr[7:0]] : 16'h0000;
    assign w1_dq_in   = !w1_oe_n ? mem1[w1_addr[7:0]] : 16'h0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [15:0] addr, input logic [15:0] data);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        step();
        req_valid = 1'b0;
    endtask

    task automatic start1(input logic we, input logic [15:0] addr, input logic [15:0] data);
        r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = data;
        step();
        r1_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++;
        if ({req_ready, rsp_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 6'b101110) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 101110",
                     {req_ready, rsp_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        n_checks++;
        if ({rsp_rdata, sram_addr, sram_dq_out} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {rsp_rdata, sram_addr, sram_dq_out});
        end
        rst = 1'b0;
        start(1'b1, 16'h0010, 16'h1111);
        step();
        n_checks++;
        if (sram_we_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_precond_we_n: got %b expected 0", sram_we_n);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            n_fail++;
            $display("FAIL rst_mid_async_pins: got %b expected 1110",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_checks++;
        if ({req_ready, rsp_valid, sram_ce_n} !== 3'b101) begin
            n_fail++;
            $display("FAIL rst_release: got %b expected 101", {req_ready, rsp_valid, sram_ce_n});
        end
    endtask

    task automatic test_single_write();
        logic [5:0] exp;
        start(1'b1, 16'h1234, 16'hBEEF);
        for (int c = 1; c <= 6; c++) begin
            exp = {c > 4, 1'b1, !(c == 2 || c == 3), c <= 4, c == 5, c >= 5};
            n_checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid, req_ready} !== exp) begin
                n_fail++;
                $display("FAIL write_pins c%0d: got %b expected %b", c,
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid, req_ready}, exp);
            end
            if (c <= 4) begin
                n_checks++;
                if ({sram_addr, sram_dq_out} !== 32'h1234_BEEF) begin
                    n_fail++;
                    $display("FAIL write_addr_data c%0d: got %h expected 1234beef", c, {sram_addr, sram_dq_out});
                end
            end
            step();
        end
    endtask

    task automatic test_read_back();
        logic [5:0] exp;
        start(1'b0, 16'h1234, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            exp = {c > 4, c > 3, 1'b1, 1'b0, c == 5, c >= 5};
            n_checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid, req_ready} !== exp) begin
                n_fail++;
                $display("FAIL read_pins c%0d: got %b expected %b", c,
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, rsp_valid, req_ready}, exp);
            end
            if (c == 5) begin
                n_checks++;
                if (rsp_rdata !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL read_rdata: got %h expected beef", rsp_rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        start(1'b1, 16'h0001, 16'h00AA);
        repeat (4) step();
        n_checks++;
        if ({rsp_valid, req_ready, rsp_rdata} !== {2'b11, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL b2b_write_rsp: got %h expected 3beef", {rsp_valid, req_ready, rsp_rdata});
        end
        start(1'b0, 16'h0001, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            exp = {c > 3, 1'b1, c == 5, c >= 5};
            n_checks++;
            if ({sram_oe_n, sram_we_n, rsp_valid, req_ready} !== exp) begin
                n_fail++;
                $display("FAIL b2b_read_pins c%0d: got %b expected %b", c,
                         {sram_oe_n, sram_we_n, rsp_valid, req_ready}, exp);
            end
            if (c == 5) begin
                n_checks++;
                if (rsp_rdata !== 16'h00AA) begin
                    n_fail++;
                    $display("FAIL b2b_rdata: got %h expected 00aa", rsp_rdata);
                end
            end
            step();
        end
    endtask

    task automatic test_req_stability();
        start(1'b1, 16'h0020, 16'h5A5A);
        req_addr = 16'hFFFF;
        req_wdata = 16'hFFFF;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({sram_addr, sram_dq_out, sram_dq_oe} !== {16'h0020, 16'h5A5A, 1'b1}) begin
                n_fail++;
                $display("FAIL stability c%0d: got %h/%h oe %b expected 0020/5a5a oe 1",
                         c, sram_addr, sram_dq_out, sram_dq_oe);
            end
            step();
        end
        step();
    endtask

    task automatic test_wait1();
        logic [2:0] exp;
        start1(1'b1, 16'h0042, 16'h1357);
        for (int c = 1; c <= 4; c++) begin
            exp = {1'b1, c != 2, c == 4};
            n_checks++;
            if ({w1_oe_n, w1_we_n, w1_rsp_valid} !== exp) begin
                n_fail++;
                $display("FAIL w1_write c%0d: got %b expected %b", c, {w1_oe_n, w1_we_n, w1_rsp_valid}, exp);
            end
            step();
        end
        start1(1'b0, 16'h0042, 16'h0000);
        for (int c = 1; c <= 4; c++) begin
            exp = {c > 2, 1'b1, c == 4};
            n_checks++;
            if ({w1_oe_n, w1_we_n, w1_rsp_valid} !== exp) begin
                n_fail++;
                $display("FAIL w1_read c%0d: got %b expected %b", c, {w1_oe_n, w1_we_n, w1_rsp_valid}, exp);
            end
            if (c == 4) begin
                n_checks++;
                if (w1_rdata !== 16'h1357) begin
                    n_fail++;
                    $display("FAIL w1_rdata: got %h expected 1357", w1_rdata);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_back_to_back();
        test_req_stability();
        test_wait1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
